perceptron_trainer: RTL and testbench
=====================================

# perceptron_trainer

Training sequencer that drives the single-layer perceptron, the counterpart to the perceptron's sample/teacher input port. On START it presents the four input combinations of (X1, X2) in a fixed order, each paired with the teacher bit from a programmable 2-input truth table. It samples the perceptron's output Z for every sample and counts misclassifications per epoch. It stops when enough consecutive error-free epochs have been seen (converged) or when an epoch budget runs out (not converged).

## Interface
- TEACH_FN, 4'b1101, teacher truth table; S = TEACH_FN[{X2,X1}] (4'b1101 = !X1|X2, 4'b0100 = !X1&X2)
- HOLD, 1, clock cycles each sample is held (1..15)
- CONV_EPOCHS, 2, consecutive zero-error epochs required for convergence (1..15)
- MAX_EPOCHS, 15, epoch budget (1..255)
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  begin a training run; sampled only in IDLE and DONE
- Z  in  1  perceptron output for the currently driven sample
- X1  out  1  perceptron input 1 (registered)
- X2  out  1  perceptron input 2 (registered)
- S  out  1  teacher bit, registered together with X1/X2
- BUSY  out  1  run in progress
- DONE  out  1  run finished; held until next START or reset
- CONVERGED  out  1  valid when DONE: 1 = converged, 0 = budget exhausted
- EPOCH  out  8  epochs completed in the current or last run
- ERR_CNT  out  3  misclassifications in the most recently completed epoch (0..4)

## Operation
- Reset (RST_N low, asynchronous): state IDLE. X1 = X2 = S = 0, BUSY = DONE = CONVERGED = 0, EPOCH = 0, ERR_CNT = 0. Internal sample index, hold counter, epoch error accumulator and clean-epoch counter are all cleared.
- States and transitions:
  - IDLE → RUN on START.
  - RUN → DONE on termination.
  - DONE → RUN on START.
- START in RUN is ignored.
- Entering RUN:
  - Clears EPOCH, ERR_CNT, the accumulator, the clean counter and CONVERGED.
  - Clears DONE.
  - Drives sample index k = 0.
  - Sets BUSY = 1.
- Sample order per epoch: k = 0, 1, 2, 3, with X1 = k[0] and X2 = k[1], so (X2,X1) = 00, 01, 10, 11.
- S = TEACH_FN[k]. S is updated on the same edge as X1/X2, so teacher and inputs are always aligned.
- Evaluation: on the last edge of a sample's hold window, an error is recorded if Z != S. That same edge drives the next sample.
- Epoch end, at the evaluation edge of k = 3:
  - ERR_CNT ← total errors in the epoch, including this sample.
  - EPOCH increments.
  - Accumulator clears.
  - Clean counter increments if the epoch had zero errors; otherwise it clears to 0.
- Termination, checked at epoch end:
  - If the clean counter reaches CONV_EPOCHS: DONE = 1, CONVERGED = 1, BUSY = 0.
  - Otherwise, if EPOCH reaches MAX_EPOCHS: DONE = 1, CONVERGED = 0, BUSY = 0.
  - If both conditions hit on the same edge, convergence wins.
- In DONE, X1/X2/S hold the last driven sample (k = 3). The perceptron keeps seeing a constant sample.
- EPOCH saturates by construction, since MAX_EPOCHS ≤ 255.

## Timing
- START sampled high at edge E0 (in IDLE/DONE) → at E0:
  - X1/X2/S = sample 0.
  - BUSY = 1.
- Sample k is driven at edge E0 + k·HOLD within the first epoch.
- Sample k is evaluated at edge E0 + (k+1)·HOLD.
- Epoch length is 4·HOLD cycles.
- The end of epoch n (1-based) falls on edge E0 + 4·HOLD·n. ERR_CNT, EPOCH, DONE, CONVERGED and BUSY all update on that edge.
- Minimum run: CONV_EPOCHS·4·HOLD cycles. Maximum run: MAX_EPOCHS·4·HOLD cycles.
- Z is treated as combinational from X1/X2 and the perceptron weights. It is sampled with no extra pipeline delay.
- Reset asserted mid-run: outputs go to reset values immediately, with no clock required. No run resumes after release; a new START is required.
- START held high continuously: starts exactly one run. After DONE, the next edge with START high (which can be the edge following the DONE edge) starts a new run.

## Test plan
- Mirror test: TEACH_FN = 4'b1101, HOLD = 1, CONV_EPOCHS = 2; bench drives Z = S; START at E0. Required response:
  - X sequence 00, 01, 10, 11, 00, ...
  - DONE = CONVERGED = 1 at E0+8, with EPOCH = 2 and ERR_CNT = 0.
- Stuck-at-0 output: Z = 0, TEACH_FN = 4'b1101, MAX_EPOCHS = 3. Required response:
  - ERR_CNT = 3 at E0+4, E0+8 and E0+12.
  - DONE = 1, CONVERGED = 0, EPOCH = 3 at E0+12.
- AND teacher with HOLD = 2, Z = S:
  - TEACH_FN = 4'b0100 → S = 1 only while (X2,X1) = 10, held for 2 cycles.
  - Converges at E0+16 with CONV_EPOCHS = 2.
- Clean-run reset: Z = S in epoch 1, one forced error in epoch 2, then Z = S, with CONV_EPOCHS = 2. Required response:
  - After epoch 2, ERR_CNT = 1 and the clean counter resets.
  - Converges at the end of epoch 4, with EPOCH = 4.
- Control corner cases:
  - START pulsed mid-run → no restart; EPOCH keeps counting.
  - RST_N pulled low mid-epoch → all outputs 0 before the next edge.
  - START after DONE → DONE clears and EPOCH = 0 on that edge.
- Real DUT: connect the perceptron with TEACH_FN = 4'b1101 and MAX_EPOCHS = 15. Required response:
  - X1/X2/S aligned every cycle.
  - DONE asserts within 60 cycles.
  - CONVERGED equals the reference model's verdict.

Source files
------------

// File: rtl/perceptron_trainer.sv
// Training sequencer for a 2-input perceptron: sweeps the four input combinations,
// scores Z against a programmable teacher table and stops on convergence or budget.
module perceptron_trainer #(
  parameter logic [3:0] TEACH_FN    = 4'b1101,
  parameter int         HOLD        = 1,
  parameter int         CONV_EPOCHS = 2,
  parameter int         MAX_EPOCHS  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       z,
  output logic       x1,
  output logic       x2,
  output logic       s,
  output logic       busy,
  output logic       done,
  output logic       converged,
  output logic [7:0] epoch,
  output logic [2:0] err_cnt
);

  // state    | meaning
  // ST_IDLE  | after reset, waiting for start
  // ST_RUN   | presenting samples and scoring Z
  // ST_DONE  | run finished, last sample held, waiting for start
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
  localparam logic [3:0] CONV_N    = 4'(CONV_EPOCHS);
  localparam logic [7:0] MAX_N     = 8'(MAX_EPOCHS);

  state_t     state, state_nxt;
  logic [1:0] k, k_inc;
  logic [3:0] hold_cnt;
  logic [2:0] acc, err_total;
  logic [3:0] clean, clean_nxt;
  logic [7:0] epoch_nxt;
  logic       launch, eval, miss, epoch_end, conv_hit, budget_hit, finish;

  assign x1 = k[0];
  assign x2 = k[1];

  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    eval       = 1'b0;
    miss       = 1'b0;
    epoch_end  = 1'b0;
    k_inc      = k + 2'd1;
    err_total  = acc;
    clean_nxt  = 4'd0;
    epoch_nxt  = epoch + 8'd1;
    conv_hit   = 1'b0;
    budget_hit = 1'b0;
    finish     = 1'b0;

    launch    = (state != ST_RUN) && start;
    eval      = (state == ST_RUN) && (hold_cnt == 4'd0);
    miss      = eval && (z != s);
    epoch_end = eval && (k == 2'd3);
    err_total = acc + {2'b00, miss};
    clean_nxt = (err_total == 3'd0) ? clean + 4'd1 : 4'd0;
    // convergence takes priority when both limits land on the same epoch
    conv_hit   = epoch_end && (clean_nxt == CONV_N);
    budget_hit = epoch_end && (epoch_nxt == MAX_N);
    finish     = conv_hit || budget_hit;

    case (state)
      ST_IDLE: if (start)  state_nxt = ST_RUN;
      ST_RUN:  if (finish) state_nxt = ST_DONE;
      ST_DONE: if (start)  state_nxt = ST_RUN;
      default:             state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k         <= 2'd0;
      s         <= 1'b0;
      hold_cnt  <= 4'd0;
      acc       <= 3'd0;
      clean     <= 4'd0;
      epoch     <= 8'd0;
      err_cnt   <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
    end else if (launch) begin
      k         <= 2'd0;
      s         <= TEACH_FN[0];
      hold_cnt  <= HOLD_LAST;
      acc       <= 3'd0;
      clean     <= 4'd0;
      epoch     <= 8'd0;
      err_cnt   <= 3'd0;
      busy      <= 1'b1;
      done      <= 1'b0;
      converged <= 1'b0;
    end else if (eval) begin
      if (epoch_end) begin
        err_cnt <= err_total;
        epoch   <= epoch_nxt;
        acc     <= 3'd0;
        clean   <= clean_nxt;
      end else begin
        acc <= err_total;
      end
      // on the final edge the sample is frozen so the perceptron sees k = 3
      if (finish) begin
        busy      <= 1'b0;
        done      <= 1'b1;
        converged <= conv_hit;
      end else begin
        k        <= k_inc;
        s        <= TEACH_FN[k_inc];
        hold_cnt <= HOLD_LAST;
      end
    end else if (state == ST_RUN) begin
      hold_cnt <= hold_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: mirror, stuck-at-0, AND teacher, clean-run reset,
// control corner cases and a small learning perceptron in the loop.
module tb_perceptron_trainer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_mir, start_stk, start_and, start_real, force_err;
  int   checks = 0;
  int   errors = 0;
  int   cyc;
  logic [3:0] teach_or = 4'b1101;

  logic       mir_z, mir_x1, mir_x2, mir_s, mir_busy, mir_done, mir_conv;
  logic [7:0] mir_epoch;
  logic [2:0] mir_err;
  logic       stk_x1, stk_x2, stk_s, stk_busy, stk_done, stk_conv;
  logic [7:0] stk_epoch;
  logic [2:0] stk_err;
  logic       and_z, and_x1, and_x2, and_s, and_busy, and_done, and_conv;
  logic [7:0] and_epoch;
  logic [2:0] and_err;
  logic       real_z, real_x1, real_x2, real_s, real_busy, real_done, real_conv;
  logic [7:0] real_epoch;
  logic [2:0] real_err;

  assign mir_z = mir_s ^ force_err;
  assign and_z = and_s;

  // learning perceptron: z = (b + w1*x1 + w2*x2 > 0), weights nudged on every scored sample
  int w1, w2, b;
  assign real_z = (b + w1 * int'(real_x1) + w2 * int'(real_x2)) > 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1 <= 0; w2 <= 0; b <= 0;
    end else if (real_busy) begin
      b  <= b + (int'(real_s) - int'(real_z));
      w1 <= w1 + (int'(real_s) - int'(real_z)) * int'(real_x1);
      w2 <= w2 + (int'(real_s) - int'(real_z)) * int'(real_x2);
    end
  end

  perceptron_trainer #(.TEACH_FN(4'b1101), .HOLD(1), .CONV_EPOCHS(2), .MAX_EPOCHS(15)) u_mir (
    .clk(clk), .rst_n(rst_n), .start(start_mir), .z(mir_z), .x1(mir_x1), .x2(mir_x2), .s(mir_s),
    .busy(mir_busy), .done(mir_done), .converged(mir_conv), .epoch(mir_epoch), .err_cnt(mir_err));

  perceptron_trainer #(.TEACH_FN(4'b1101), .HOLD(1), .CONV_EPOCHS(2), .MAX_EPOCHS(3)) u_stk (
    .clk(clk), .rst_n(rst_n), .start(start_stk), .z(1'b0), .x1(stk_x1), .x2(stk_x2), .s(stk_s),
    .busy(stk_busy), .done(stk_done), .converged(stk_conv), .epoch(stk_epoch), .err_cnt(stk_err));

  perceptron_trainer #(.TEACH_FN(4'b0100), .HOLD(2), .CONV_EPOCHS(2), .MAX_EPOCHS(15)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start_and), .z(and_z), .x1(and_x1), .x2(and_x2), .s(and_s),
    .busy(and_busy), .done(and_done), .converged(and_conv), .epoch(and_epoch), .err_cnt(and_err));

  perceptron_trainer #(.TEACH_FN(4'b1101), .HOLD(1), .CONV_EPOCHS(2), .MAX_EPOCHS(15)) u_real (
    .clk(clk), .rst_n(rst_n), .start(start_real), .z(real_z), .x1(real_x1), .x2(real_x2), .s(real_s),
    .busy(real_busy), .done(real_done), .converged(real_conv), .epoch(real_epoch), .err_cnt(real_err));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start_mir = 1'b0; start_stk = 1'b0; start_and = 1'b0; start_real = 1'b0;
    force_err = 1'b0;
    #2;
    check("rst_x", {6'd0, mir_x2, mir_x1}, 8'd0);
    check("rst_s", {7'd0, mir_s}, 8'd0);
    check("rst_busy", {7'd0, mir_busy}, 8'd0);
    check("rst_done", {7'd0, mir_done}, 8'd0);
    check("rst_conv", {7'd0, mir_conv}, 8'd0);
    check("rst_epoch", mir_epoch, 8'd0);
    check("rst_err", {5'd0, mir_err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // mirror: Z = S
    start_mir = 1'b1; tick(); start_mir = 1'b0;
    check("mir_e0_x", {6'd0, mir_x2, mir_x1}, 8'd0);
    check("mir_e0_s", {7'd0, mir_s}, 8'd1);
    check("mir_e0_busy", {7'd0, mir_busy}, 8'd1);
    tick();
    check("mir_e1_x", {6'd0, mir_x2, mir_x1}, 8'd1);
    check("mir_e1_s", {7'd0, mir_s}, 8'd0);
    tick();
    check("mir_e2_x", {6'd0, mir_x2, mir_x1}, 8'd2);
    tick();
    check("mir_e3_x", {6'd0, mir_x2, mir_x1}, 8'd3);
    tick();
    check("mir_e4_x", {6'd0, mir_x2, mir_x1}, 8'd0);
    check("mir_e4_epoch", mir_epoch, 8'd1);
    check("mir_e4_err", {5'd0, mir_err}, 8'd0);
    repeat (3) tick();
    check("mir_e7_done", {7'd0, mir_done}, 8'd0);
    tick();
    check("mir_e8_done", {7'd0, mir_done}, 8'd1);
    check("mir_e8_conv", {7'd0, mir_conv}, 8'd1);
    check("mir_e8_epoch", mir_epoch, 8'd2);
    check("mir_e8_busy", {7'd0, mir_busy}, 8'd0);
    check("mir_e8_hold_x", {6'd0, mir_x2, mir_x1}, 8'd3);
    tick();
    check("mir_e9_done_held", {7'd0, mir_done}, 8'd1);

    // clean-run reset with a mid-run START pulse
    start_mir = 1'b1; tick(); start_mir = 1'b0;
    check("cr_restart_done", {7'd0, mir_done}, 8'd0);
    check("cr_restart_epoch", mir_epoch, 8'd0);
    check("cr_restart_busy", {7'd0, mir_busy}, 8'd1);
    repeat (5) tick();
    force_err = 1'b1; tick(); force_err = 1'b0;
    repeat (2) tick();
    check("cr_e8_err", {5'd0, mir_err}, 8'd1);
    check("cr_e8_epoch", mir_epoch, 8'd2);
    tick();
    start_mir = 1'b1; tick(); start_mir = 1'b0;
    check("cr_midstart_epoch", mir_epoch, 8'd2);
    check("cr_midstart_busy", {7'd0, mir_busy}, 8'd1);
    repeat (2) tick();
    check("cr_e12_epoch", mir_epoch, 8'd3);
    check("cr_e12_done", {7'd0, mir_done}, 8'd0);
    repeat (4) tick();
    check("cr_e16_done", {7'd0, mir_done}, 8'd1);
    check("cr_e16_conv", {7'd0, mir_conv}, 8'd1);
    check("cr_e16_epoch", mir_epoch, 8'd4);

    // stuck-at-0 output, budget of 3 epochs
    start_stk = 1'b1; tick(); start_stk = 1'b0;
    repeat (4) tick();
    check("stk_e4_err", {5'd0, stk_err}, 8'd3);
    check("stk_e4_epoch", stk_epoch, 8'd1);
    repeat (4) tick();
    check("stk_e8_err", {5'd0, stk_err}, 8'd3);
    check("stk_e8_done", {7'd0, stk_done}, 8'd0);
    repeat (4) tick();
    check("stk_e12_err", {5'd0, stk_err}, 8'd3);
    check("stk_e12_done", {7'd0, stk_done}, 8'd1);
    check("stk_e12_conv", {7'd0, stk_conv}, 8'd0);
    check("stk_e12_epoch", stk_epoch, 8'd3);
    check("stk_e12_busy", {7'd0, stk_busy}, 8'd0);

    // AND teacher, HOLD = 2
    start_and = 1'b1; tick(); start_and = 1'b0;
    check("and_e0", {5'd0, and_s, and_x2, and_x1}, 8'b000);
    tick();
    check("and_e1", {5'd0, and_s, and_x2, and_x1}, 8'b000);
    tick();
    check("and_e2", {5'd0, and_s, and_x2, and_x1}, 8'b001);
    repeat (2) tick();
    check("and_e4", {5'd0, and_s, and_x2, and_x1}, 8'b110);
    tick();
    check("and_e5", {5'd0, and_s, and_x2, and_x1}, 8'b110);
    tick();
    check("and_e6", {5'd0, and_s, and_x2, and_x1}, 8'b011);
    repeat (2) tick();
    check("and_e8_epoch", and_epoch, 8'd1);
    repeat (7) tick();
    check("and_e15_done", {7'd0, and_done}, 8'd0);
    tick();
    check("and_e16_done", {7'd0, and_done}, 8'd1);
    check("and_e16_conv", {7'd0, and_conv}, 8'd1);
    check("and_e16_epoch", and_epoch, 8'd2);

    // learning perceptron in the loop: 3 errors in epoch 1, then clean; converges at E0+12
    start_real = 1'b1; tick(); start_real = 1'b0;
    cyc = 0;
    while (!real_done && cyc < 60) begin
      check("real_align", {7'd0, real_s}, {7'd0, teach_or[{real_x2, real_x1}]});
      tick();
      cyc++;
    end
    check("real_done", {7'd0, real_done}, 8'd1);
    check("real_cycles", 8'(cyc), 8'd12);
    check("real_conv", {7'd0, real_conv}, 8'd1);
    check("real_epoch", real_epoch, 8'd3);

    // asynchronous reset mid-epoch
    start_mir = 1'b1; tick(); start_mir = 1'b0;
    repeat (2) tick();
    check("ar_pre_busy", {7'd0, mir_busy}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_x", {6'd0, mir_x2, mir_x1}, 8'd0);
    check("ar_s", {7'd0, mir_s}, 8'd0);
    check("ar_busy", {7'd0, mir_busy}, 8'd0);
    check("ar_done", {7'd0, mir_done}, 8'd0);
    check("ar_epoch", mir_epoch, 8'd0);
    check("ar_stk_done", {7'd0, stk_done}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("ar_no_resume", {7'd0, mir_busy}, 8'd0);
    check("ar_no_resume_x", {6'd0, mir_x2, mir_x1}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
